// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and transmitter FSM states.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy output; head visible combinationally, no added latency.
// Backpressure: a push while full is dropped, a pop while empty is ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a start/data/parity/stop serialiser.
// tx falls one edge after a character reaches an idle block; ready drops when the FIFO is full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKRATE    = 12000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid,
  input  logic [DATA_BITS-1:0]        data,
  output logic                        ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int DIVISOR = CLKRATE / BAUDRATE;
  localparam int CNT_W   = $clog2(STOP_BITS * DIVISOR + 1);
  localparam int BIT_W   = $clog2(DATA_BITS);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t BIT_RELOAD  = cnt_t'(DIVISOR - 1);
  localparam cnt_t STOP_RELOAD = cnt_t'(STOP_BITS * DIVISOR - 1);

  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_tx_fifo: CLKRATE/BAUDRATE must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t               state;
  cnt_t                 baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 bit_end;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (valid),
    .wdata (data),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign ready   = !full;
  assign busy    = (state != ST_IDLE);
  assign bit_end = (baud_cnt == '0);
  // Popping at the end of STOP chains frames without an idle cycle.
  assign pop     = !empty && (state == ST_IDLE || (state == ST_STOP && bit_end));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else if (pop) begin
      state    <= ST_START;
      baud_cnt <= BIT_RELOAD;
      shreg    <= head;
      par_bit  <= (^head) ^ (PARITY == PARITY_ODD);
      tx       <= 1'b0;
    end else if (state != ST_IDLE && !bit_end) begin
      baud_cnt <= baud_cnt - 1'b1;
    end else begin
      case (state)
        ST_START: begin
          state    <= ST_DATA;
          baud_cnt <= BIT_RELOAD;
          bit_cnt  <= '0;
          tx       <= shreg[0];
          shreg    <= shreg >> 1;
        end
        ST_DATA: begin
          baud_cnt <= BIT_RELOAD;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) begin
              state <= ST_PARITY;
              tx    <= par_bit;
            end else begin
              state    <= ST_STOP;
              baud_cnt <= STOP_RELOAD;
              tx       <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        ST_PARITY: begin
          state    <= ST_STOP;
          baud_cnt <= STOP_RELOAD;
          tx       <= 1'b1;
        end
        ST_STOP: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 7N2) at DIVISOR=2,
// each tracked by a frame-level model of the line, plus literal frame expectations.
module tb_uart_tx_fifo;
  localparam int NCFG = 4;
  localparam int DIV  = 2;
  localparam int DEP  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_v [NCFG];
  logic [8:0] data_v  [NCFG];
  logic       tx_w    [NCFG];
  logic       busy_w  [NCFG];
  logic       ready_w [NCFG];
  logic [2:0] level_w [NCFG];

  int   n_checks = 0;
  int   n_fails  = 0;
  logic s [64];

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int DB  = (g == 3) ? 7 : 8;
    localparam int PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;

    uart_tx_fifo #(
      .CLKRATE(10), .BAUDRATE(5), .DATA_BITS(DB), .PARITY(PAR),
      .STOP_BITS(SB), .FIFO_DEPTH(DEP)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .valid (valid_v[g]),
      .data  (data_v[g][DB-1:0]),
      .ready (ready_w[g]),
      .tx    (tx_w[g]),
      .busy  (busy_w[g]),
      .level (level_w[g])
    );

    // Line model: a queue of pending characters and a queue of per-cycle tx values.
    int q[$];
    int wave[$];
    int fb[$];
    int exp_tx   = 1;
    int exp_busy = 0;
    int sz, c, ones;

    initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        wave.delete();
        exp_tx   = 1;
        exp_busy = 0;
      end else begin
        sz = q.size();
        if (wave.size() == 0 && sz > 0) begin
          c = q.pop_front();
          ones = $countones(c);
          fb.delete();
          fb.push_back(0);
          for (int i = 0; i < DB; i++) fb.push_back((c >> i) & 1);
          if (PAR == 2) fb.push_back(ones % 2);
          if (PAR == 1) fb.push_back(1 - (ones % 2));
          for (int i = 0; i < SB; i++) fb.push_back(1);
          foreach (fb[i]) for (int r = 0; r < DIV; r++) wave.push_back(fb[i]);
        end
        if (valid_v[g] && sz < DEP) q.push_back(int'(data_v[g]) & ((1 << DB) - 1));
        if (wave.size() != 0) begin
          exp_tx   = wave.pop_front();
          exp_busy = 1;
        end else begin
          exp_tx   = 1;
          exp_busy = 0;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      check($sformatf("cfg%0d.tx", g),    int'(tx_w[g]),    exp_tx);
      check($sformatf("cfg%0d.busy", g),  int'(busy_w[g]),  exp_busy);
      check($sformatf("cfg%0d.level", g), int'(level_w[g]), q.size());
      check($sformatf("cfg%0d.ready", g), int'(ready_w[g]), int'(q.size() != DEP));
    end
  end

  task automatic push(input int g, input int v);
    @(negedge clk);
    valid_v[g] = 1'b1;
    data_v[g]  = v[8:0];
    @(posedge clk);
    #1 valid_v[g] = 1'b0;
  endtask

  task automatic capture(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s[i] = tx_w[g];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] cap;
    logic [6:0]  d7;
    logic [3:0]  st4;
    int          vals [2];
    int          bytes [6];
    int          acc, k, guard, cyc, first_b, last_b, lows, bcnt;
    logic        rdy;

    reset = 1'b1;
    for (int g = 0; g < NCFG; g++) begin
      valid_v[g] = 1'b0;
      data_v[g]  = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_tx", int'(tx_w[0]), 1);
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_level", int'(level_w[0]), 0);
    check("rst_ready", int'(ready_w[0]), 1);
    reset = 1'b0;

    // 8N1 0xAA: start, 0,1,0,1,0,1,0,1, stop; two cycles per bit.
    push(0, 'hAA);
    @(negedge clk);
    check("8n1_tx_before_start", int'(tx_w[0]), 1);
    check("8n1_level_after_accept", int'(level_w[0]), 1);
    capture(0, 20);
    cap = '0;
    for (int i = 0; i < 20; i++) cap = {cap[18:0], s[i]};
    check("8n1_frame_aa", int'(cap), 'h0CCCF);
    @(negedge clk);
    check("8n1_busy_after", int'(busy_w[0]), 0);
    repeat (3) @(negedge clk);

    // Parity bit sits at samples 18/19 of an 8-bit frame.
    vals[0] = 'hAA;
    vals[1] = 'h01;
    for (int g = 1; g <= 2; g++) begin
      for (int j = 0; j < 2; j++) begin
        push(g, vals[j]);
        @(negedge clk);
        capture(g, 22);
        check($sformatf("parity_cfg%0d_v%0h", g, vals[j]), int'(s[18]),
              (g == 1) ? ((j == 0) ? 0 : 1) : ((j == 0) ? 1 : 0));
        check($sformatf("parity_len_cfg%0d_v%0h", g, vals[j]), int'(s[19]), int'(s[18]));
        check($sformatf("stop_cfg%0d_v%0h", g, vals[j]), int'(s[20] & s[21]), 1);
        repeat (3) @(negedge clk);
      end
    end

    // 7N2 0x55 twice: 7 data bits, four stop cycles, then next start immediately.
    push(3, 'h55);
    push(3, 'h55);
    capture(3, 24);
    check("7n2_start", int'({s[0], s[1]}), 0);
    for (int i = 0; i < 7; i++) d7[i] = s[2 + 2 * i];
    check("7n2_data", int'(d7), 'h55);
    st4 = {s[16], s[17], s[18], s[19]};
    check("7n2_stop", int'(st4), 'hF);
    check("7n2_next_start", int'({s[20], s[21]}), 0);
    repeat (25) @(negedge clk);

    // Depth 4 with valid held: five accepted, back-to-back frames.
    bytes = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66};
    acc = 0; k = 0; guard = 0; cyc = 0; first_b = -1; last_b = -1;
    @(negedge clk);
    valid_v[0] = 1'b1;
    data_v[0]  = bytes[0][8:0];
    while (guard < 20) begin
      rdy = ready_w[0];
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
      cyc++;
      if (busy_w[0]) begin
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
      end
      if (rdy && k < 5) begin
        k++;
        data_v[0] = bytes[k][8:0];
      end
      if (level_w[0] == 3'd4) break;
      guard++;
    end
    check("depth_full_level", int'(level_w[0]), 4);
    check("depth_ready_low", int'(ready_w[0]), 0);
    check("depth_accepted", acc, 5);
    guard = 0;
    while (guard < 40) begin
      @(negedge clk);
      cyc++;
      if (busy_w[0]) last_b = cyc;
      if (level_w[0] == 3'd3) break;
      guard++;
    end
    check("pushpop_full_level", int'(level_w[0]), 3);
    check("pushpop_ready_rise", int'(ready_w[0]), 1);
    valid_v[0] = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      cyc++;
      if (busy_w[0]) last_b = cyc;
    end
    check("depth_busy_span", last_b - first_b + 1, 100);
    check("depth_drained_level", int'(level_w[0]), 0);

    // Reset during the data bits of 0x00 with two characters queued.
    push(0, 'h00);
    push(0, 'h5A);
    push(0, 'hC3);
    repeat (4) @(negedge clk);
    check("midrst_tx_low_before", int'(tx_w[0]), 0);
    check("midrst_level_before", int'(level_w[0]), 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx_high", int'(tx_w[0]), 1);
    check("midrst_level_zero", int'(level_w[0]), 0);
    check("midrst_busy_low", int'(busy_w[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0; bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!tx_w[0]) lows++;
      if (busy_w[0]) bcnt++;
    end
    check("postrst_tx_low_cycles", lows, 0);
    check("postrst_busy_cycles", bcnt, 0);

    // Accept on the first edge after reset release.
    @(negedge clk);
    reset      = 1'b1;
    valid_v[0] = 1'b1;
    data_v[0]  = 9'h081;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    @(negedge clk);
    check("first_accept_level", int'(level_w[0]), 1);
    repeat (25) @(negedge clk);
    check("first_accept_done", int'(busy_w[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKRATE, default 12000000: clk frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200: line bit rate; DIVISOR = CLKRATE/BAUDRATE (integer, truncated), DIVISOR >= 1 enforced by elaboration check.
REQ-003 SHALL have parameter DATA_BITS, default 8: character width, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even; other values rejected at elaboration.
REQ-005 SHALL have parameter STOP_BITS, default 1: legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: power of two, >= 2.
REQ-007 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-009 SHALL have port valid  input  1: write request.
REQ-010 SHALL have port data  input  DATA_BITS: character to send.
REQ-011 SHALL have port ready  output  1: FIFO not full; a character is accepted on a rising edge with valid && ready.
REQ-012 SHALL have port tx  output  1: serial line, idle high, registered.
REQ-013 SHALL have port busy  output  1: high while a frame is on the line.
REQ-014 SHALL have port level  output  $clog2(FIFO_DEPTH)+1: FIFO occupancy.

Function
REQ-015 Accepted characters SHALL be stored in FIFO order; ready = (level != FIFO_DEPTH), combinational from occupancy.
REQ-016 A push while full SHALL be ignored (ready low); a simultaneous push and pop SHALL leave level unchanged.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: if level != 0, the FSM SHALL pop the head into a shift register and enter START on the same edge; tx therefore goes low on the second rising edge after acceptance into an empty, idle block.
REQ-019 Each bit SHALL last exactly DIVISOR clk cycles, timed by a baud counter reloaded at each state entry.
REQ-020 START SHALL drive tx = 0 and then go to DATA.
REQ-021 DATA SHALL shift LSB first for DATA_BITS bits and then go to PARITY if PARITY != 0, else to STOP.
REQ-022 PARITY SHALL drive XOR of the data bits for even and its inverse for odd.
REQ-023 STOP SHALL drive tx = 1 for STOP_BITS*DIVISOR cycles.
REQ-024 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START on that edge with no idle gap; otherwise it SHALL enter IDLE.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 The bit counter SHALL count up to DATA_BITS-1 without wrap beyond; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 The data input SHALL be sampled only on accept; changes to data while not accepted SHALL have no effect.

Reset
REQ-028 While reset is high: tx = 1, busy = 0, level = 0, ready = 1, FSM in IDLE, counters zero.
REQ-029 Reset mid-frame SHALL abort the frame immediately (tx high asynchronously) and flush the FIFO; no partial frame resumes after release.
REQ-030 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-031 Package uart_pkg SHALL hold the parity encodings (PARITY_NONE/ODD/EVEN) and the FSM state enumeration.
REQ-032 The FIFO SHALL be a separate sub-module, uart_fifo (synchronous, parametrised width/depth, exposes level); the FSM and baud timing stay in uart_tx_fifo.

Verification (CLKRATE=10, BAUDRATE=5, so DIVISOR=2)
REQ-033 8N1: push 0xAA -> tx = 0,0,1,0,1,0,1,0,1,1 bits (start, LSB first, stop), each 2 cycles, 20 cycles total; busy low afterwards.
REQ-034 8E1 and 8O1: push 0xAA -> parity bit 0 (even) / 1 (odd); push 0x01 -> 1 (even) / 0 (odd).
REQ-035 7N2: push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then tx high 4 cycles before the next frame.
REQ-036 FIFO_DEPTH=4, valid held high with 6 distinct bytes -> 5 accepted, ready low when level=4; all 5 frames sent back-to-back with no idle cycle between stop and start.
REQ-037 Reset asserted during DATA of 0x00 with 2 queued -> tx high at once, level 0; after release tx stays high and no frame is sent until the next push.
REQ-038 Push and pop on the same edge at level 4 with valid high -> push rejected; level goes 4 to 3 and ready rises.
